alu_flag_seq: RTL
=================

// Module: alu_flag_seq
// PURPOSE
//   Registered, handshaked ALU with an architectural NZCV flag register and an iterative
//   shift-add multiplier. Generalises the combinational ALU-with-flags: N-bit width,
//   3-bit op select, conditional flag update (ARM S-bit semantics) and multi-cycle MUL.
//   Sits in the execute stage of the multi-cycle core between the register file and writeback.
// PARAMETERS
//   N       32  operand/result width (>= 4)
//   MUL_EN  1   1: MUL op implemented; 0: MUL behaves as an unsupported op
// PORTS
//   clk        in   1  clock, all state on rising edge
//   reset      in   1  synchronous, active-high reset
//   in_valid   in   1  operation request valid
//   in_ready   out  1  block can accept a request this cycle
//   a          in   N  operand A
//   b          in   N  operand B
//   alu_ctl    in   3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL, 11x unsupported
//   set_flags  in   1  1: update NZCV register on completion of this op
//   out_valid  out  1  result valid, held until out_ready
//   out_ready  in   1  consumer accepts result
//   result     out  N  registered result
//   nzcv       out  4  flag register {N,Z,C,V}
//   busy       out  1  high in MUL state
// BEHAVIOUR
//   - Reset: state=IDLE, in_ready=1, out_valid=0, result=0, nzcv=4'b0000, busy=0,
//     multiplier accumulator/counter cleared. Reset wins over every other input, any state.
//   - Accept = in_valid & in_ready; a, b, alu_ctl, set_flags captured on accept.
//   - in_ready = (state==IDLE) | (state==DONE & out_ready) -> back-to-back single-cycle
//     ops at one per clock when consumer always ready.
//   - States: IDLE -accept non-MUL-> DONE; IDLE -accept MUL-> MUL; MUL -(N iters done)-> DONE;
//     DONE -out_ready & accept non-MUL-> DONE; DONE -out_ready & accept MUL-> MUL;
//     DONE -out_ready & !accept-> IDLE; DONE -!out_ready-> DONE (result, out_valid held).
//   - Latency: ADD/SUB/AND/ORR/EOR/unsupported: out_valid the cycle after accept.
//     MUL: exactly N cycles in MUL (one bit of b per cycle, LSB first), out_valid N+1 cycles
//     after accept. in_valid ignored while in MUL.
//   - Arithmetic: ADD {c,r}=a+b (N+1 bits); SUB {c,r}=a+~b+1 (c=1 means no borrow).
//     V (ADD) = (a[N-1]==b[N-1]) & (r[N-1]!=a[N-1]); V (SUB) = (a[N-1]!=b[N-1]) & (r[N-1]!=a[N-1]).
//     MUL result = low N bits of a*b (unsigned, wraps).
//   - Flags, written in the same edge that raises out_valid, only if captured set_flags=1:
//     N=r[N-1], Z=(r==0) for all ops; C,V updated for ADD/SUB only, preserved otherwise.
//   - Unsupported op (11x, or 101 with MUL_EN=0): result=0, nzcv unchanged regardless of
//     set_flags, completes with single-cycle latency.
//   - set_flags=0: nzcv never changes. nzcv stable while out_valid held.
//   - Reset mid-MUL: partial product discarded, no out_valid, nzcv cleared.
// TESTING
//   1. ADD a=32'hFFFFFFFF b=1 set_flags=1 -> 1 cycle later out_valid, result=0, nzcv=4'b0110.
//   2. SUB a=32'h80000000 b=1 set_flags=1 -> result=32'h7FFFFFFF, nzcv=4'b0011;
//      then AND a=0 b=0 set_flags=1 -> nzcv=4'b0111 (C,V preserved, Z set).
//   3. MUL a=1000 b=1000 -> busy for 32 cycles, out_valid on cycle 33, result=1000000;
//      in_valid during busy is not accepted (in_ready=0).
//   4. Backpressure: ADD 5+7 with out_ready=0 for 4 cycles -> result=12 and out_valid held,
//      in_ready=0; new request accepted the cycle out_ready=1.
//   5. Back-to-back ADDs with out_ready=1 -> one result per cycle; set_flags=0 on
//      second op leaves nzcv from first.
//   6. reset=1 at MUL iteration 10 -> next cycle IDLE, out_valid=0, nzcv=0, in_ready=1.

Source files
------------

// File: rtl/alu_flag_seq.sv
// alu_flag_seq
//   Registered, handshaked ALU for the execute stage of the multi-cycle core.
//   It holds an architectural NZCV flag register and has an iterative
//   shift-add multiplier. Single-cycle ops complete the cycle after accept.
//   MUL spends N cycles iterating over b, LSB first.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   request valid
//   in_ready   request can be accepted this cycle
//   a, b       N-bit operands
//   alu_ctl    000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL, 11x unsupported
//   set_flags  update NZCV when this op completes
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   result     registered N-bit result
//   nzcv       flag register {N,Z,C,V}
//   busy       multiplier iterating
//
// State | meaning
//   IDLE | no result pending, ready for a request
//   MUL  | shift-add multiply in progress, requests ignored
//   DONE | result presented, waiting for out_ready
module alu_flag_seq #(
  parameter int N      = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   alu_ctl,
  input  logic         set_flags,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   nzcv,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  logic [1:0]    r_state;
  logic [N-1:0]  r_result;
  logic [3:0]    r_nzcv;
  logic          r_out_valid;
  logic          r_sf;
  logic [N-1:0]  r_acc;
  logic [N-1:0]  r_mcand;
  logic [N-1:0]  r_mplier;
  logic [CW-1:0] r_cnt;

  logic          w_accept;
  logic          w_is_mul;
  logic [N:0]    w_sum;
  logic [N:0]    w_dif;
  logic [N-1:0]  w_res;
  logic          w_c;
  logic          w_v;
  logic          w_supported;
  logic [N-1:0]  w_acc_next;
  logic          w_mul_last;

  assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign nzcv      = r_nzcv;
  assign busy      = (r_state == S_MUL);

  assign w_accept = in_valid & in_ready;
  assign w_is_mul = MUL_EN && (alu_ctl == OP_MUL);

  assign w_sum = {1'b0, a} + {1'b0, b};
  // Subtract as a + ~b + 1 so carry out means "no borrow".
  assign w_dif = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);

  always_comb begin
    w_res       = '0;
    w_c         = r_nzcv[1];
    w_v         = r_nzcv[0];
    w_supported = 1'b1;
    case (alu_ctl)
      OP_ADD: begin
        w_res = w_sum[N-1:0];
        w_c   = w_sum[N];
        w_v   = (a[N-1] == b[N-1]) & (w_sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        w_res = w_dif[N-1:0];
        w_c   = w_dif[N];
        w_v   = (a[N-1] != b[N-1]) & (w_dif[N-1] != a[N-1]);
      end
      OP_AND: w_res = a & b;
      OP_ORR: w_res = a | b;
      OP_EOR: w_res = a ^ b;
      // MUL never reaches this path when enabled; when disabled it is unsupported.
      default: w_supported = 1'b0;
    endcase
  end

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mul_last = (r_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_nzcv      <= 4'b0000;
      r_out_valid <= 1'b0;
      r_sf        <= 1'b0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // DONE without out_ready holds everything in place.
          if ((r_state == S_IDLE) || out_ready) begin
            if (w_accept) begin
              if (w_is_mul) begin
                r_state     <= S_MUL;
                r_out_valid <= 1'b0;
                r_sf        <= set_flags;
                r_acc       <= '0;
                r_mcand     <= a;
                r_mplier    <= b;
                r_cnt       <= CW'(N);
              end else begin
                r_state     <= S_DONE;
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                if (set_flags && w_supported)
                  r_nzcv <= {w_res[N-1], (w_res == '0), w_c, w_v};
              end
            end else begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
          if (w_mul_last) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_acc_next;
            // MUL only touches N and Z; C and V carry over.
            if (r_sf)
              r_nzcv <= {w_acc_next[N-1], (w_acc_next == '0), r_nzcv[1:0]};
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
